// File: rtl/mult_share_arb.sv
// rtl/mult_share_arb.sv - round-robin scheduler sharing one pipelined multiplier
// Optional build macro: MULT_SHARE_PRIO0_EN (requester 0 gets strict priority).
module mult_share_arb #(
    parameter int N_REQ   = 4,
    parameter int R       = 14,
    parameter int MUL_LAT = 5,
    parameter int IDW     = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*R-1:0]   req_a,
    input  logic [N_REQ*R-1:0]   req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic [R-1:0]         mul_a,
    output logic [R-1:0]         mul_b,
    input  logic [2*R-1:0]       mul_p,
    output logic                 res_valid,
    output logic [IDW-1:0]       res_id,
    output logic [2*R-1:0]       res_p,
    output logic                 busy
);

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   gnt_id;
    logic             gnt_any;
    int               cand;

    logic [R-1:0]     mul_a_q, mul_b_q;
    logic [MUL_LAT:0] vld_q;
    logic [IDW-1:0]   id_q [MUL_LAT+1];
    logic             res_valid_q;
    logic [IDW-1:0]   res_id_q;
    logic [2*R-1:0]   res_p_q;

    always_comb begin
        req_ready = '0;
        gnt_id    = '0;
        gnt_any   = 1'b0;
        ptr_d     = ptr_q;
        cand      = 0;
`ifdef MULT_SHARE_PRIO0_EN
        // Requester 0 bypasses the rotation; ptr only tracks requesters 1..N_REQ-1.
        if (en && req_valid[0]) begin
            gnt_any = 1'b1;
        end else if (en) begin
            for (int k = 1; k < N_REQ; k++) begin
                cand = int'(ptr_q) + k;
                if (cand > N_REQ - 1) cand = cand - (N_REQ - 1);
                if (!gnt_any && req_valid[cand]) begin
                    gnt_any = 1'b1;
                    gnt_id  = IDW'(cand);
                    ptr_d   = IDW'(cand);
                end
            end
        end
`else
        if (en) begin
            for (int k = 1; k <= N_REQ; k++) begin
                cand = int'(ptr_q) + k;
                if (cand >= N_REQ) cand = cand - N_REQ;
                if (!gnt_any && req_valid[cand]) begin
                    gnt_any = 1'b1;
                    gnt_id  = IDW'(cand);
                    ptr_d   = IDW'(cand);
                end
            end
        end
`endif
        if (gnt_any) req_ready[gnt_id] = 1'b1;
    end

    // Tag pipeline is one stage longer than the multiplier so the last stage
    // lines up with mul_p for the operands issued from mul_a_q/mul_b_q.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q       <= IDW'(N_REQ - 1);
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            vld_q       <= '0;
            for (int i = 0; i <= MUL_LAT; i++) id_q[i] <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_p_q     <= '0;
        end else begin
            if (gnt_any) begin
                mul_a_q <= req_a[gnt_id*R +: R];
                mul_b_q <= req_b[gnt_id*R +: R];
            end
            ptr_q   <= ptr_d;
            vld_q   <= {vld_q[MUL_LAT-1:0], gnt_any};
            id_q[0] <= gnt_id;
            for (int i = 1; i <= MUL_LAT; i++) id_q[i] <= id_q[i-1];
            res_valid_q <= vld_q[MUL_LAT];
            res_id_q    <= id_q[MUL_LAT];
            res_p_q     <= mul_p;
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_p     = res_p_q;
    assign busy      = (|vld_q) | res_valid_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// tb/tb_mult_share_arb.sv - directed self-checking bench for mult_share_arb
module tb_mult_share_arb;
    localparam int N_REQ   = 4;
    localparam int R       = 14;
    localparam int MUL_LAT = 5;
    localparam int IDW     = 2;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 en;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ*R-1:0]   req_a, req_b;
    logic [N_REQ-1:0]     req_ready;
    logic [R-1:0]         mul_a, mul_b;
    logic [2*R-1:0]       mul_p;
    logic                 res_valid;
    logic [IDW-1:0]       res_id;
    logic [2*R-1:0]       res_p;
    logic                 busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mult_share_arb #(.N_REQ(N_REQ), .R(R), .MUL_LAT(MUL_LAT), .IDW(IDW)) dut (
        .clk(clk), .rstn(rstn), .en(en),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .res_valid(res_valid), .res_id(res_id), .res_p(res_p), .busy(busy)
    );

    // External multiplier: input register plus 4 output levels, never reset.
    logic [2*R-1:0] mp [MUL_LAT];
    always @(posedge clk) begin
        mp[0] <= {{R{1'b0}}, mul_a} * {{R{1'b0}}, mul_b};
        for (int i = 1; i < MUL_LAT; i++) mp[i] <= mp[i-1];
    end
    assign mul_p = mp[MUL_LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [R-1:0] a, input logic [R-1:0] b);
        req_a[i*R +: R] = a;
        req_b[i*R +: R] = b;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req_valid = '0;
        tick();
        tick();
        rstn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        #2;
        n_cmp++; if (mul_a !== '0) begin n_err++; $display("FAIL reset_mul_a got %h exp 0", mul_a); end
        n_cmp++; if (mul_b !== '0) begin n_err++; $display("FAIL reset_mul_b got %h exp 0", mul_b); end
        n_cmp++; if (res_p !== '0) begin n_err++; $display("FAIL reset_res_p got %h exp 0", res_p); end
        n_cmp++; if (res_id !== '0) begin n_err++; $display("FAIL reset_res_id got %h exp 0", res_id); end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        tick();
        tick();
        rstn = 1'b1;
        #1;
    endtask

    task automatic test_single();
        en = 1'b1;
        set_op(0, 14'd3, 14'd5);
        req_valid = 4'b0001;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready got %b exp 0001", req_ready); end
        tick();
        req_valid = '0;
        for (int k = 0; k <= 8; k++) begin
            n_cmp++;
            if (res_valid !== (k == 6)) begin n_err++; $display("FAIL single_res_valid k=%0d got %b exp %b", k, res_valid, (k == 6)); end
            n_cmp++;
            if (busy !== (k <= 6)) begin n_err++; $display("FAIL single_busy k=%0d got %b exp %b", k, busy, (k <= 6)); end
            if (k == 6) begin
                n_cmp++; if (res_id !== 2'd0) begin n_err++; $display("FAIL single_res_id got %0d exp 0", res_id); end
                n_cmp++; if (res_p !== 28'd15) begin n_err++; $display("FAIL single_res_p got %0d exp 15", res_p); end
            end
            tick();
        end
    endtask

    task automatic test_all_valid();
        logic [N_REQ-1:0] exp_rdy;
        logic [IDW-1:0]   exp_id;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < N_REQ; i++) set_op(i, R'(i + 1), 14'd10);
        req_valid = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            #1;
`ifdef MULT_SHARE_PRIO0_EN
            exp_rdy = 4'b0001;
`else
            exp_rdy = 4'(1 << (j % 4));
`endif
            n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL all_ready j=%0d got %b exp %b", j, req_ready, exp_rdy); end
            tick();
        end
        req_valid = '0;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
`ifdef MULT_SHARE_PRIO0_EN
            exp_id = 2'd0;
`else
            exp_id = IDW'(k % 4);
`endif
            n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL all_res_valid k=%0d got %b exp 1", k, res_valid); end
            n_cmp++; if (res_id !== exp_id) begin n_err++; $display("FAIL all_res_id k=%0d got %0d exp %0d", k, res_id, exp_id); end
            n_cmp++; if (res_p !== 28'((exp_id + 1) * 10)) begin n_err++; $display("FAIL all_res_p k=%0d got %0d exp %0d", k, res_p, (exp_id + 1) * 10); end
            tick();
        end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL all_res_end got %b exp 0", res_valid); end
    endtask

    task automatic test_single_requester();
        en = 1'b1;
        set_op(2, 14'h3FFF, 14'h3FFF);
        req_valid = 4'b0100;
        for (int j = 0; j < 5; j++) begin
            #1;
            n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL one_ready j=%0d got %b exp 0100", j, req_ready); end
            tick();
        end
        req_valid = '0;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL one_res_valid k=%0d got %b exp 1", k, res_valid); end
            n_cmp++; if (res_id !== 2'd2) begin n_err++; $display("FAIL one_res_id k=%0d got %0d exp 2", k, res_id); end
            n_cmp++; if (res_p !== 28'hFFF8001) begin n_err++; $display("FAIL one_res_p k=%0d got %h exp FFF8001", k, res_p); end
            tick();
        end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL one_res_end got %b exp 0", res_valid); end
    endtask

    task automatic test_en_drop();
        int pulses;
        logic rdy_seen;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < N_REQ; i++) set_op(i, 14'd2, 14'd2);
        req_valid = 4'b1111;
        tick();
        tick();
        en = 1'b0;
        pulses = 0;
        rdy_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (req_ready !== '0) rdy_seen = 1'b1;
            if (res_valid === 1'b1) pulses++;
            tick();
        end
        n_cmp++; if (rdy_seen !== 1'b0) begin n_err++; $display("FAIL endrop_ready got %b exp 0", rdy_seen); end
        n_cmp++; if (pulses != 2) begin n_err++; $display("FAIL endrop_pulses got %0d exp 2", pulses); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL endrop_busy got %b exp 0", busy); end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        logic seen;
        en = 1'b1;
        set_op(1, 14'd7, 14'd9);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        tick();
        tick();
        rstn = 1'b0;
        #1;
        n_cmp++; if (mul_a !== '0) begin n_err++; $display("FAIL rmid_mul_a got %h exp 0", mul_a); end
        n_cmp++; if (mul_b !== '0) begin n_err++; $display("FAIL rmid_mul_b got %h exp 0", mul_b); end
        n_cmp++; if (res_p !== '0) begin n_err++; $display("FAIL rmid_res_p got %h exp 0", res_p); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b exp 0", busy); end
        tick();
        rstn = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (res_valid === 1'b1) seen = 1'b1;
            tick();
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rmid_stale_result got %b exp 0", seen); end
        req_valid = 4'b1111;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rmid_first_grant got %b exp 0001", req_ready); end
        req_valid = '0;
        tick();
    endtask

`ifdef MULT_SHARE_PRIO0_EN
    task automatic test_prio0();
        logic [N_REQ-1:0] exp_rdy [4];
        exp_rdy[0] = 4'b0010; exp_rdy[1] = 4'b0100; exp_rdy[2] = 4'b1000; exp_rdy[3] = 4'b0010;
        do_reset();
        en = 1'b1;
        req_valid = 4'b1111;
        for (int j = 0; j < 4; j++) begin
            #1;
            n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL prio_ready0 j=%0d got %b exp 0001", j, req_ready); end
            tick();
        end
        req_valid = 4'b1110;
        for (int j = 0; j < 4; j++) begin
            #1;
            n_cmp++; if (req_ready !== exp_rdy[j]) begin n_err++; $display("FAIL prio_rr j=%0d got %b exp %b", j, req_ready, exp_rdy[j]); end
            tick();
        end
        req_valid = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_all_valid();
        test_single_requester();
        test_en_drop();
        test_reset_mid();
`ifdef MULT_SHARE_PRIO0_EN
        test_prio0();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
